// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI request arbiter slice.
//   - one-hot controller state encoding (IDLE/BUSY/GAP)
//   - frame width and read/write encodings of spi_wr_ctrl
//   - per-requester command struct (rd flag + write data)
package spi_ctrl_pkg;

  localparam int SPI_FRAME_W = 16;

  // spi_wr_ctrl encodings
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  localparam logic [2:0] ST_IDLE_OH = 3'b001;
  localparam logic [2:0] ST_BUSY_OH = 3'b010;
  localparam logic [2:0] ST_GAP_OH  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_OH,
    ST_BUSY = ST_BUSY_OH,
    ST_GAP  = ST_GAP_OH
  } state_e;

  typedef struct packed {
    logic                   rd;
    logic [SPI_FRAME_W-1:0] wdata;
  } spi_cmd_t;

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Bundle of requester-side handshakes and spi_master frame signals.
//   slave  : arbiter view (takes requests, drives ack/err/rdata and the frame command)
//   master : environment view (requesters + spi_master)
//   req0/1, rd0/1, wdata0/1 : request level, read flag, write data
//   ack0/1, err0/1, rdata0/1: completion pulse, timeout flag, read data
//   spi_en, spi_sdata, spi_wr_ctrl : frame command to spi_master
//   spi_rdata, spi_done            : frame result from spi_master
interface spi_req_arbiter_if;
  import spi_ctrl_pkg::*;

  logic                   req0, req1;
  logic                   rd0, rd1;
  logic [SPI_FRAME_W-1:0] wdata0, wdata1;
  logic                   ack0, ack1;
  logic                   err0, err1;
  logic [SPI_FRAME_W-1:0] rdata0, rdata1;
  logic                   spi_en;
  logic [SPI_FRAME_W-1:0] spi_sdata;
  logic                   spi_wr_ctrl;
  logic [SPI_FRAME_W-1:0] spi_rdata;
  logic                   spi_done;

  modport slave (
    input  req0, req1, rd0, rd1, wdata0, wdata1, spi_rdata, spi_done,
    output ack0, ack1, err0, err1, rdata0, rdata1, spi_en, spi_sdata, spi_wr_ctrl
  );

  modport master (
    output req0, req1, rd0, rd1, wdata0, wdata1, spi_rdata, spi_done,
    input  ack0, ack1, err0, err1, rdata0, rdata1, spi_en, spi_sdata, spi_wr_ctrl
  );

endinterface

// File: rtl/spi_req_arbiter_rr_arb2.sv
// 2-way round-robin arbiter.
//   req_i[1:0]   : request levels
//   grant_en_i   : a grant is taken this cycle (pointer advances when a request wins)
//   gnt_id_o     : winning requester
//   gnt_valid_o  : at least one request present
// ptr_q names the requester preferred on contention; it moves to the other
// requester on every grant taken, so after reset requester 0 wins a tie.
module spi_rr_arb2 (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic       gnt_id_o,
  output logic       gnt_valid_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_valid_o = |req_i;
    unique case (req_i)
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ptr_q;
      default: gnt_id_o = 1'b0;
    endcase
    ptr_d = ptr_q;
    if (grant_en_i && gnt_valid_o) ptr_d = ~gnt_id_o;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Front-end controller sharing one spi_master between two requesters.
// Round-robin grant, one frame at a time, timeout on a missing spi_done,
// and a fixed idle gap after every completion.
//   sys_clk, rst_n : clock, async active-low reset
//   bus            : requester handshakes + spi_master frame signals
//   busy_o         : controller not in IDLE
//   grant_id_o     : requester owning the current/last frame
module spi_req_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 8
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  spi_req_arbiter_if.slave    bus,
  output logic                busy_o,
  output logic                grant_id_o
);

  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  state_e                          state_q, state_d;
  logic [TO_W-1:0]                 to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]                gap_cnt_q, gap_cnt_d;
  logic                            en_q, en_d;
  logic [SPI_FRAME_W-1:0]          sdata_q, sdata_d;
  logic                            wr_ctrl_q, wr_ctrl_d;
  logic                            gid_q, gid_d;
  logic [1:0]                      ack_q, ack_d;
  logic [1:0]                      err_q, err_d;
  logic [1:0][SPI_FRAME_W-1:0]     rdata_q, rdata_d;

  spi_cmd_t [1:0] cmd;
  logic           gnt_id, gnt_valid;

  assign cmd[0] = '{rd: bus.rd0, wdata: bus.wdata0};
  assign cmd[1] = '{rd: bus.rd1, wdata: bus.wdata1};

  spi_rr_arb2 u_arb (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .req_i       ({bus.req1, bus.req0}),
    .grant_en_i  (state_q == ST_IDLE),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    en_d      = en_q;
    sdata_d   = sdata_q;
    wr_ctrl_d = wr_ctrl_q;
    gid_d     = gid_q;
    ack_d     = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          // Command fields are captured here only; later req/wdata changes do not matter.
          sdata_d   = (cmd[gnt_id].rd == RD) ? '0 : cmd[gnt_id].wdata;
          wr_ctrl_d = cmd[gnt_id].rd;
          en_d      = 1'b1;
          gid_d     = gnt_id;
          to_cnt_d  = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // spi_done has priority over a timeout landing in the same cycle.
        if (bus.spi_done) begin
          en_d          = 1'b0;
          ack_d[gid_q]  = 1'b1;
          if (wr_ctrl_q == RD) rdata_d[gid_q] = bus.spi_rdata;
          gap_cnt_d     = '0;
          state_d       = ST_GAP;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          en_d          = 1'b0;
          ack_d[gid_q]  = 1'b1;
          err_d[gid_q]  = 1'b1;
          gap_cnt_d     = '0;
          state_d       = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) state_d = ST_IDLE;
        else                                  gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      en_q      <= 1'b0;
      sdata_q   <= '0;
      wr_ctrl_q <= WR;
      gid_q     <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      en_q      <= en_d;
      sdata_q   <= sdata_d;
      wr_ctrl_q <= wr_ctrl_d;
      gid_q     <= gid_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.spi_en      = en_q;
  assign bus.spi_sdata   = sdata_q;
  assign bus.spi_wr_ctrl = wr_ctrl_q;
  assign bus.ack0        = ack_q[0];
  assign bus.ack1        = ack_q[1];
  assign bus.err0        = err_q[0];
  assign bus.err1        = err_q[1];
  assign bus.rdata0      = rdata_q[0];
  assign bus.rdata1      = rdata_q[1];
  assign busy_o          = (state_q != ST_IDLE);
  assign grant_id_o      = gid_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
module tb_spi_req_arbiter;

  localparam int TO  = 64;
  localparam int GAP = 8;

  logic sys_clk, rst_n;
  logic busy, gid;
  spi_req_arbiter_if bif();

  spi_req_arbiter #(.TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .bus        (bif),
    .busy_o     (busy),
    .grant_id_o (gid)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- slave / spi_master stand-in ----------------
  bit          slave_on = 1'b1;
  int          slave_dly = 5;
  logic [15:0] slave_rdata = 16'h0;
  int          force_tok = 0;
  int          s_seen = 0;
  int          s_cnt = 0;
  bit          s_fired = 1'b0;

  always @(negedge sys_clk) begin
    bif.spi_done = 1'b0;
    if (!rst_n) begin
      s_cnt = 0; s_fired = 1'b0; s_seen = force_tok;
    end else if (force_tok != s_seen) begin
      s_seen = force_tok;
      bif.spi_done  = 1'b1;
      bif.spi_rdata = slave_rdata;
    end else if (bif.spi_en && slave_on && !s_fired) begin
      if (s_cnt >= slave_dly) begin
        bif.spi_done  = 1'b1;
        bif.spi_rdata = slave_rdata;
        s_fired = 1'b1;
      end
      s_cnt++;
    end
    if (!bif.spi_en) begin s_cnt = 0; s_fired = 1'b0; end
  end

  // ---------------- behavioural model ----------------
  // Owner of the running frame (-1 none), BUSY cycles elapsed, gap cycles left,
  // last requester served, and the registered outputs the rules imply.
  int          m_owner, m_age, m_gap, m_last;
  logic [15:0] m_sdata;
  logic        m_rd, m_gid;
  logic [15:0] m_rdata [2];
  logic        m_ack [2];
  logic        m_err [2];

  function automatic int winner(input logic r0, input logic r1, input int last);
    if (r0 && r1) return 1 - last;
    return r1 ? 1 : 0;
  endfunction

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_age <= 0; m_gap <= 0; m_last <= 1;
      m_sdata <= '0; m_rd <= 1'b0; m_gid <= 1'b0;
      m_rdata[0] <= '0; m_rdata[1] <= '0;
      m_ack[0] <= 1'b0; m_ack[1] <= 1'b0; m_err[0] <= 1'b0; m_err[1] <= 1'b0;
    end else begin
      m_ack[0] <= 1'b0; m_ack[1] <= 1'b0; m_err[0] <= 1'b0; m_err[1] <= 1'b0;
      if (m_owner >= 0) begin
        if (bif.spi_done || m_age == TO) begin
          m_owner <= -1;
          m_gap   <= GAP;
          m_ack[m_owner] <= 1'b1;
          if (!bif.spi_done)  m_err[m_owner] <= 1'b1;
          else if (m_rd)      m_rdata[m_owner] <= bif.spi_rdata;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (m_gap > 0) begin
        m_gap <= m_gap - 1;
      end else if (bif.req0 || bif.req1) begin
        m_owner <= winner(bif.req0, bif.req1, m_last);
        m_last  <= winner(bif.req0, bif.req1, m_last);
        m_gid   <= 1'(winner(bif.req0, bif.req1, m_last));
        m_age   <= 1;
        if (winner(bif.req0, bif.req1, m_last) == 0) begin
          m_rd <= bif.rd0; m_sdata <= bif.rd0 ? 16'h0 : bif.wdata0;
        end else begin
          m_rd <= bif.rd1; m_sdata <= bif.rd1 ? 16'h0 : bif.wdata1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clk) begin
    chk("spi_en",      32'(bif.spi_en),      32'(m_owner >= 0));
    chk("busy",        32'(busy),            32'((m_owner >= 0) || (m_gap > 0)));
    chk("spi_sdata",   32'(bif.spi_sdata),   32'(m_sdata));
    chk("spi_wr_ctrl", 32'(bif.spi_wr_ctrl), 32'(m_rd));
    chk("grant_id",    32'(gid),             32'(m_gid));
    chk("ack0",        32'(bif.ack0),        32'(m_ack[0]));
    chk("ack1",        32'(bif.ack1),        32'(m_ack[1]));
    chk("err0",        32'(bif.err0),        32'(m_err[0]));
    chk("err1",        32'(bif.err1),        32'(m_err[1]));
    chk("rdata0",      32'(bif.rdata0),      32'(m_rdata[0]));
    chk("rdata1",      32'(bif.rdata1),      32'(m_rdata[1]));
  end

  // ---------------- observation log ----------------
  int grant_log[$];
  int hi_log[$];
  int lo_log[$];
  int hi_len = 0, lo_len = 0;
  bit en_prev = 1'b0;
  int ack0_cnt = 0, ack1_cnt = 0, err0_cnt = 0, err1_cnt = 0;

  always @(negedge sys_clk) begin
    if (bif.spi_en) begin
      if (!en_prev) begin grant_log.push_back(int'(gid)); lo_log.push_back(lo_len); hi_len = 0; end
      hi_len++;
    end else begin
      if (en_prev) begin hi_log.push_back(hi_len); lo_len = 0; end
      lo_len++;
    end
    en_prev = bif.spi_en;
    ack0_cnt += int'(bif.ack0); ack1_cnt += int'(bif.ack1);
    err0_cnt += int'(bif.err0); err1_cnt += int'(bif.err1);
  end

  task automatic wait_ack(input int port, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge sys_clk);
      if ((port == 0 && bif.ack0) || (port == 1 && bif.ack1)) ok = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit ok;
    int b0, b1, g0, h0, n;
    rst_n = 1'b0;
    bif.req0 = 0; bif.req1 = 0; bif.rd0 = 0; bif.rd1 = 0;
    bif.wdata0 = '0; bif.wdata1 = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_spi_en", 32'(bif.spi_en), 32'h0);
    chk("rst_busy",   32'(busy),       32'h0);
    chk("rst_rdata0", 32'(bif.rdata0), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // single write
    b0 = ack0_cnt;
    bif.req0 = 1; bif.rd0 = 0; bif.wdata0 = 16'hA5C3;
    @(negedge sys_clk);
    chk("wr_grant_latency", 32'(bif.spi_en),    32'h1);
    chk("wr_sdata",         32'(bif.spi_sdata), 32'hA5C3);
    chk("wr_wr_ctrl",       32'(bif.spi_wr_ctrl), 32'h0);
    wait_ack(0, 200, ok);
    chk("wr_ack_seen", 32'(ok), 32'h1);
    chk("wr_err0",     32'(bif.err0), 32'h0);
    bif.req0 = 0;
    repeat (12) @(negedge sys_clk);
    chk("wr_ack_count", 32'(ack0_cnt - b0), 32'h1);

    // single read on port 1
    slave_rdata = 16'h1234;
    bif.req1 = 1; bif.rd1 = 1; bif.wdata1 = 16'hFFFF;
    @(negedge sys_clk);
    chk("rd_grant_id", 32'(gid),             32'h1);
    chk("rd_sdata",    32'(bif.spi_sdata),   32'h0);
    chk("rd_wr_ctrl",  32'(bif.spi_wr_ctrl), 32'h1);
    wait_ack(1, 200, ok);
    chk("rd_ack_seen", 32'(ok),          32'h1);
    chk("rd_rdata1",   32'(bif.rdata1),  32'h1234);
    chk("rd_rdata0",   32'(bif.rdata0),  32'h0);
    bif.req1 = 0; bif.rd1 = 0;
    repeat (12) @(negedge sys_clk);

    // contention: both held for four frames
    g0 = grant_log.size();
    bif.wdata0 = 16'h1111; bif.wdata1 = 16'h2222;
    bif.req0 = 1; bif.req1 = 1;
    n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge sys_clk);
      if (bif.ack0 || bif.ack1) n++;
    end
    bif.req0 = 0; bif.req1 = 0;
    chk("cont_acks", 32'(n), 32'h4);
    repeat (12) @(negedge sys_clk);
    if (grant_log.size() >= g0 + 4) begin
      for (int i = 0; i < 4; i++) chk("cont_grant_order", 32'(grant_log[g0+i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk("cont_gap_len", 32'(lo_log[g0+i]), 32'd9);
    end else begin
      chk("cont_frames", 32'(grant_log.size() - g0), 32'h4);
    end

    // timeout on requester 0, then requester 1 served normally
    slave_on = 1'b0;
    g0 = grant_log.size(); h0 = hi_log.size();
    b0 = err0_cnt;
    bif.req0 = 1; bif.req1 = 1;
    wait_ack(0, 200, ok);
    chk("to_ack_seen", 32'(ok),       32'h1);
    chk("to_err0",     32'(bif.err0), 32'h1);
    slave_on = 1'b1;
    bif.req0 = 0;
    wait_ack(1, 200, ok);
    chk("to_next_ack1", 32'(ok),       32'h1);
    chk("to_next_err1", 32'(bif.err1), 32'h0);
    bif.req1 = 0;
    repeat (12) @(negedge sys_clk);
    chk("to_err_count", 32'(err0_cnt - b0), 32'h1);
    if (hi_log.size() > h0) chk("to_en_len", 32'(hi_log[h0]), 32'd64);
    else                    chk("to_en_len_missing", 32'(hi_log.size() - h0), 32'h1);
    if (grant_log.size() >= g0 + 2) begin
      chk("to_first_grant", 32'(grant_log[g0]),   32'h0);
      chk("to_next_grant",  32'(grant_log[g0+1]), 32'h1);
    end else begin
      chk("to_frames", 32'(grant_log.size() - g0), 32'h2);
    end

    // early drop of req0
    slave_dly = 10;
    g0 = grant_log.size(); b0 = ack0_cnt;
    bif.req0 = 1; bif.wdata0 = 16'h0BEE;
    @(negedge sys_clk);
    repeat (2) @(negedge sys_clk);
    bif.req0 = 0;
    wait_ack(0, 200, ok);
    chk("drop_ack_seen", 32'(ok), 32'h1);
    repeat (30) @(negedge sys_clk);
    chk("drop_frames",    32'(grant_log.size() - g0), 32'h1);
    chk("drop_ack_count", 32'(ack0_cnt - b0),         32'h1);

    // stray spi_done while idle
    b0 = ack0_cnt; b1 = ack1_cnt;
    slave_rdata = 16'hDEAD;
    force_tok++;
    repeat (5) @(negedge sys_clk);
    chk("stray_acks",   32'((ack0_cnt - b0) + (ack1_cnt - b1)), 32'h0);
    chk("stray_rdata1", 32'(bif.rdata1), 32'h1234);

    // reset in the middle of a read frame
    slave_dly = 30;
    bif.req1 = 1; bif.rd1 = 1;
    @(negedge sys_clk);
    repeat (3) @(negedge sys_clk);
    chk("mid_en_before", 32'(bif.spi_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en",     32'(bif.spi_en),      32'h0);
    chk("mid_rst_busy",   32'(busy),            32'h0);
    chk("mid_rst_wrctl",  32'(bif.spi_wr_ctrl), 32'h0);
    chk("mid_rst_rdata1", 32'(bif.rdata1),      32'h0);
    chk("mid_rst_gid",    32'(gid),             32'h0);
    bif.req1 = 0; bif.rd1 = 0;
    repeat (3) @(negedge sys_clk);
    b1 = ack1_cnt; g0 = grant_log.size();
    rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("mid_no_ack",    32'(ack1_cnt - b1),         32'h0);
    chk("mid_no_frames", 32'(grant_log.size() - g0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
